// File: rtl/hclk_rate_meter_pkg.sv
// Shared types and sizing helpers for the divided-clock rate meter.
// Used by hclk_rate_meter and hclk_sync_edge.
package hclk_rate_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        REPORT = 2'd3
    } state_t;

    // One cycle per synchroniser flop plus one for the prev-sample flop,
    // so a stale edge from the previous channel cannot leak into the gate.
    function automatic int settle_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/hclk_sync_edge.sv
// Multi-flop synchroniser for one divided-clock input followed by a
// prev-sample flop; rise_o is high for one clk cycle per rising edge.
module hclk_sync_edge
    import hclk_rate_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hclk_rate_meter.sv
// Round-robin rising-edge counter for divided clocks over a 2**GATE_LOG2 gate.
// Define HCLK_RATE_METER_CONTINUOUS_EN to keep sweeping instead of idling.
module hclk_rate_meter
    import hclk_rate_meter_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int GATE_LOG2   = 20,
    parameter  int CNT_W       = 16,
    parameter  int SYNC_STAGES = 2,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NUM_CH-1:0] hclk_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [CH_W-1:0]   ch_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              valid_o,
    output logic              ovf_o,
    output logic              sweep_done_o
);

    localparam int                   SETTLE_LEN  = settle_cycles(SYNC_STAGES);
    localparam int                   SET_W       = $clog2(SETTLE_LEN);
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_LEN - 1);
    localparam logic [GATE_LOG2:0]   GATE_LAST   = {1'b0, {GATE_LOG2{1'b1}}};
    localparam logic [CH_W-1:0]      CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX     = '1;

    logic [NUM_CH-1:0]      rise;
    logic [(1<<CH_W)-1:0]   rise_pad;
    logic                   rise_sel;

    state_t                 state_q;
    logic [CH_W-1:0]        ch_q;
    logic [SET_W-1:0]       settle_q;
    logic [GATE_LOG2:0]     gate_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;

    logic                   busy_q;
    logic                   valid_q;
    logic                   done_q;
    logic [CH_W-1:0]        rep_ch_q;
    logic [CNT_W-1:0]       rep_cnt_q;
    logic                   rep_ovf_q;

    // Edge detectors run on every channel all the time; only the mux is switched.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        hclk_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk    (clk),
            .resetn (resetn),
            .d_i    (hclk_i[g]),
            .rise_o (rise[g])
        );
    end

    always_comb begin
        rise_pad               = '0;
        rise_pad[NUM_CH-1:0]   = rise;
    end

    assign rise_sel = rise_pad[ch_q];

    // Saturating edge counter; ovf latches on any edge lost to saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (rise_sel) begin
            if (cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            settle_q  <= '0;
            gate_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            rep_ch_q  <= '0;
            rep_cnt_q <= '0;
            rep_ovf_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= start_i;
                    if (start_i) begin
                        state_q  <= SETTLE;
                        ch_q     <= '0;
                        settle_q <= '0;
                    end
                end
                SETTLE: begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    ovf_q  <= 1'b0;
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= GATE;
                        gate_q  <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                GATE: begin
                    busy_q <= 1'b1;
                    cnt_q  <= cnt_d;
                    ovf_q  <= ovf_d;
                    if (gate_q == GATE_LAST) begin
                        state_q <= REPORT;
                    end else begin
                        gate_q <= gate_q + 1'b1;
                    end
                end
                REPORT: begin
                    // busy stays high through the cycle valid_o is visible.
                    busy_q    <= 1'b1;
                    valid_q   <= 1'b1;
                    rep_ch_q  <= ch_q;
                    rep_cnt_q <= cnt_q;
                    rep_ovf_q <= ovf_q;
                    cnt_q     <= '0;
                    ovf_q     <= 1'b0;
                    settle_q  <= '0;
                    if (ch_q == CH_LAST) begin
                        done_q <= 1'b1;
`ifdef HCLK_RATE_METER_CONTINUOUS_EN
                        state_q <= SETTLE;
                        ch_q    <= '0;
`else
                        state_q <= IDLE;
`endif
                    end else begin
                        state_q <= SETTLE;
                        ch_q    <= ch_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign ch_o         = rep_ch_q;
    assign count_o      = rep_cnt_q;
    assign valid_o      = valid_q;
    assign ovf_o        = rep_ovf_q;
    assign sweep_done_o = done_q;

endmodule
